// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter sharing one SPI master between NUM_REQ requesters.
// Sequences chip select setup/hold, master start, completion and timeout.
module spi_txn_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int DATA_W   = 8,
    parameter int CS_SETUP = 4,
    parameter int CS_HOLD  = 4,
    parameter int TIMEOUT  = 1023
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ-1:0]        rw_i,
    input  logic [NUM_REQ*DATA_W-1:0] wdata_i,
    output logic [NUM_REQ-1:0]        grant_o,
    output logic [NUM_REQ-1:0]        done_o,
    output logic [NUM_REQ-1:0]        err_o,
    output logic [DATA_W-1:0]         rdata_o,
    output logic [NUM_REQ-1:0]        spi_cs_n_o,
    input  logic                      mst_ready_i,
    output logic                      mst_start_o,
    output logic                      mst_rw_o,
    output logic [DATA_W-1:0]         mst_wdata_o,
    input  logic                      mst_done_i,
    input  logic [DATA_W-1:0]         mst_rdata_i
);

    localparam int PTR_W   = $clog2(NUM_REQ);
    localparam int HS_MAX  = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int CNT_MAX = (HS_MAX > TIMEOUT) ? HS_MAX : TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        START,
        BUSY,
        HOLD,
        DONE
    } state_t;

    state_t             state;
    logic [PTR_W-1:0]   rr_ptr;
    logic [CNT_W-1:0]   cnt;
    logic               any_req;
    logic [PTR_W-1:0]   sel;
    logic [NUM_REQ-1:0] sel_oh;

    // Walk downward so the nearest requester after rr_ptr wins.
    always_comb begin
        int w;
        w       = 0;
        any_req = 1'b0;
        sel     = rr_ptr;
        for (int i = NUM_REQ; i >= 1; i--) begin
            w = int'(rr_ptr) + i;
            if (w >= NUM_REQ) w = w - NUM_REQ;
            if (req_i[w[PTR_W-1:0]]) begin
                any_req = 1'b1;
                sel     = w[PTR_W-1:0];
            end
        end
    end

    assign sel_oh = NUM_REQ'(1) << sel;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state       <= IDLE;
            rr_ptr      <= PTR_W'(NUM_REQ - 1);
            cnt         <= '0;
            grant_o     <= '0;
            done_o      <= '0;
            err_o       <= '0;
            rdata_o     <= '0;
            spi_cs_n_o  <= '1;
            mst_start_o <= 1'b0;
            mst_rw_o    <= 1'b0;
            mst_wdata_o <= '0;
        end else begin
            mst_start_o <= 1'b0;
            done_o      <= '0;
            err_o       <= '0;
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_o     <= sel_oh;
                        spi_cs_n_o  <= ~sel_oh;
                        mst_rw_o    <= rw_i[sel];
                        mst_wdata_o <= wdata_i[int'(sel)*DATA_W +: DATA_W];
                        rr_ptr      <= sel;
                        cnt         <= '0;
                        state       <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        cnt   <= '0;
                        state <= START;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                START: begin
                    if (mst_ready_i) begin
                        mst_start_o <= 1'b1;
                        cnt         <= '0;
                        state       <= BUSY;
                    end
                end
                BUSY: begin
                    if (mst_done_i) begin
                        if (mst_rw_o) rdata_o <= mst_rdata_i;
                        cnt   <= '0;
                        state <= HOLD;
                    end else if (cnt == TO_LAST) begin
                        err_o      <= grant_o;
                        grant_o    <= '0;
                        spi_cs_n_o <= '1;
                        state      <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        done_o     <= grant_o;
                        grant_o    <= '0;
                        spi_cs_n_o <= '1;
                        state      <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/spi_txn_arbiter.md
Name: spi_txn_arbiter

Overview:
Shares a single SPI master (control + shift datapath) between NUM_REQ requesters using round-robin arbitration. Per transaction it:
- drives a one-hot active-low chip select;
- enforces CS setup and hold times;
- issues a one-cycle start with direction and write byte to the master;
- returns read data and a completion or timeout pulse to the granted requester.

It sits between the bus-side requesters and the SPI master control block.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, transaction data width
CS_SETUP, 4, clk cycles CS is low before start (>=1)
CS_HOLD, 4, clk cycles CS stays low after master done (>=1)
TIMEOUT, 1023, max clk cycles in BUSY before abort (>=1)

Ports:
clk_i  in  1  system clock
rstn_i  in  1  asynchronous active-low reset
req_i  in  NUM_REQ  per-requester request level
rw_i  in  NUM_REQ  per-requester direction, 0=write 1=read
wdata_i  in  NUM_REQ*DATA_W  per-requester write byte, requester k at [k*DATA_W +: DATA_W]
grant_o  out  NUM_REQ  one-hot grant, held for whole transaction
done_o  out  NUM_REQ  one-cycle completion pulse to granted requester
err_o  out  NUM_REQ  one-cycle timeout pulse to granted requester
rdata_o  out  DATA_W  read data of last completed read
spi_cs_n_o  out  NUM_REQ  active-low chip selects, at most one low
mst_ready_i  in  1  SPI master idle and able to accept start
mst_start_o  out  1  one-cycle start pulse to master
mst_rw_o  out  1  direction to master, valid while granted
mst_wdata_o  out  DATA_W  write byte to master, valid while granted
mst_done_i  in  1  one-cycle pulse: master finished transaction
mst_rdata_i  in  DATA_W  master read byte, valid with mst_done_i

Behaviour:
- Reset (async assert, sync release): state IDLE; grant_o=0; done_o=0; err_o=0; rdata_o=0; spi_cs_n_o=all 1; mst_start_o=0; mst_rw_o=0; mst_wdata_o=0; RR pointer=NUM_REQ-1, so requester 0 has first priority.
- All outputs are registered.
- States: IDLE, SETUP, START, BUSY, HOLD, DONE.
- IDLE:
  - If any req_i is high, select the first requester after the RR pointer (wrapping) with req_i high.
  - Next cycle: grant_o[k]=1; spi_cs_n_o[k]=0; latch rw_i[k] and wdata_i[k] into mst_rw_o/mst_wdata_o; update RR pointer to k; go to SETUP.
- SETUP: count CS_SETUP cycles, including the entry cycle, then go to START.
- START:
  - If mst_ready_i=1: assert mst_start_o for exactly one cycle, go to BUSY.
  - Otherwise wait in START, with CS held low.
- BUSY:
  - On mst_done_i: capture mst_rdata_i into rdata_o, only when mst_rw_o=1; go to HOLD.
  - If TIMEOUT cycles pass without mst_done_i: go to DONE with the abort flag set.
  - mst_done_i outside BUSY is ignored.
- HOLD: count CS_HOLD cycles with CS low, then go to DONE.
- DONE (one cycle):
  - spi_cs_n_o all 1; grant_o=0.
  - Pulse done_o[k], or err_o[k] if aborted (never both); return to IDLE.
- Minimum idle gap between transactions: one IDLE cycle, so CS is high for >=2 cycles between transactions.
- Request rules:
  - Requester holds req_i, rw_i and wdata_i stable until its done_o/err_o pulse.
  - Dropping req_i before grant withdraws the request.
  - Dropping req_i after grant is ignored; the transaction completes.
  - Changes to rw_i/wdata_i after latching are ignored.
- Arbitration is evaluated only in IDLE; requests arriving mid-transaction wait.
- A requester still holding req_i one cycle after its done pulse is treated as a new request, lowest priority under RR.
- Reset mid-transaction: immediate return to reset values; CS deasserts asynchronously; no done/err pulse.
- Counters sized to ceil(log2(max(CS_SETUP, CS_HOLD, TIMEOUT)+1)) bits; no wrap inside a state.

Test Plan:
- Single write: CS_SETUP=4, CS_HOLD=4, req_i=0001, rw=0, wdata0=0xA5, master done 16 cycles after start.
  -> cs_n[0] low 1 cycle after req; start pulse after 4 cycles with mst_wdata_o=0xA5; done_o[0] pulses 4 cycles after mst_done_i; cs_n[0] high in the DONE cycle.
- Read capture: req_i[2] with rw=1; master returns 0x3C with mst_done_i.
  -> rdata_o=0x3C by done_o[2]; a following write leaves rdata_o=0x3C.
- Fairness: req_i=1111 held continuously.
  -> grant order 0,1,2,3,0; never two cs_n low; >=2 cycles CS high between transactions.
- Master stall and timeout:
  - mst_ready_i=0 for 10 cycles in START -> no start pulse until ready, CS held low.
  - TIMEOUT=20 with no mst_done_i -> err_o pulses once 20 cycles after start, done_o stays 0, CS released.
- Withdrawal: req1 raised then dropped while requester 0 is in BUSY.
  -> requester 1 is never granted; arbiter returns to IDLE.
- Reset mid-BUSY: rstn_i low during BUSY.
  -> cs_n all 1 and grant_o=0 immediately (asynchronous); no done/err pulse; after release, req_i=1111 grants requester 0 first.
